// File: rtl/mem_cmd_responder.sv
// rtl/mem_cmd_responder.sv - executes CLEAR/READ/WRITE commands on a req/ack word-memory port; optional MEM_TIMEOUT_EN ack timeout
module mem_cmd_responder #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int CLEAR_WORDS = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        modeInput,
    input  logic [ADDR_W-1:0] ioAddress,
    input  logic [DATA_W-1:0] ioDataIn,
    input  logic              ioDone,
    output logic              memDone,
    output logic [DATA_W-1:0] readData,
    output logic              readValid,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata,
    output logic              errFlag
);

    localparam int CNT_W = $clog2(CLEAR_WORDS) + 1;

    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_IDLE  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_NEXT
    } state_t;

    state_t            r_state;
    state_t            w_state_n;

    logic              r_io_done_q;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;

    logic              r_mem_done;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_rise;
    logic              w_accept;
    logic              w_last_word;
    logic              w_more_words;
    logic              w_timeout;

    assign w_rise       = ioDone & ~r_io_done_q;
    assign w_accept     = (r_state == S_IDLE) && w_rise && (modeInput != MODE_IDLE);
    assign w_last_word  = (r_count == CNT_W'(CLEAR_WORDS - 1));
    assign w_more_words = (r_mode == MODE_CLEAR) && !w_last_word;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    assign w_timeout = (r_state == S_WAIT_ACK) && !memAck && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign errFlag   = r_err;

    // Cycles spent in WAIT_ACK for the current word; restarts for every request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state != S_WAIT_ACK) begin
            r_tmo <= '0;
        end else if (!memAck) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Sticky error: set on any ack timeout, only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    // No timeout hardware: error output is constant low (TIMEOUT kept in the expression so both builds consume it).
    assign w_timeout = 1'b0;
    assign errFlag   = 1'b0 & (TIMEOUT == 0);
`endif

    assign memDone   = r_mem_done;
    assign readData  = r_read_data;
    assign readValid = r_read_valid;
    assign memReq    = r_mem_req;
    assign memWe     = r_mem_we;
    assign memAddr   = r_mem_addr;
    assign memWdata  = r_mem_wdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic: one request per word, CLEAR loops through NEXT until the last word is acked.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_n = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (memAck) begin
                    w_state_n = w_more_words ? S_NEXT : S_IDLE;
                end else if (w_timeout) begin
                    w_state_n = S_IDLE;
                end
            end
            S_NEXT: begin
                w_state_n = S_ISSUE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Command latch, memory-port drive and completion reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_io_done_q  <= 1'b1;
            r_mode       <= MODE_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_count      <= '0;
            r_mem_done   <= 1'b1;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_io_done_q  <= ioDone;
            r_read_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode     <= modeInput;
                        r_addr     <= ioAddress;
                        r_data     <= ioDataIn;
                        r_count    <= '0;
                        r_mem_done <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= (r_mode == MODE_WRITE) || (r_mode == MODE_CLEAR);
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= (r_mode == MODE_CLEAR) ? '0 : r_data;
                end
                S_WAIT_ACK: begin
                    if (memAck) begin
                        r_mem_req <= 1'b0;
                        if (r_mode == MODE_READ) begin
                            r_read_data  <= memRdata;
                            r_read_valid <= 1'b1;
                        end
                        if (!w_more_words) begin
                            r_mem_done <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_mem_req  <= 1'b0;
                        r_mem_done <= 1'b1;
                    end
                end
                S_NEXT: begin
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
